// File: rtl/delay_step_controller.sv
// delay_step_controller: sequences NumberOfSteps delay/step cycles against an external delay timer.
// Ports: Clock (rising edge), Resetn (async, active-low), Run (level enable / abort),
//   Timeout (one-cycle timer pulse), StartDelay (timer enable; 0 clears it),
//   Step (one-cycle pulse per accepted Timeout), StepCount (steps issued this run),
//   Done (sequence complete), Busy (ARM/WAIT/STEP), Error (watchdog fault).
// Optional feature: define DELAY_WATCHDOG_EN to fault when WAIT lasts WatchdogLimit cycles.
module delay_step_controller #(
  parameter int NumberOfSteps = 10,
  parameter int CountBits     = 4,
  parameter int WatchdogLimit = 50000000,
  parameter int WatchdogBits  = 26
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Run,
  input  logic                 Timeout,
  output logic                 StartDelay,
  output logic                 Step,
  output logic [CountBits-1:0] StepCount,
  output logic                 Done,
  output logic                 Busy,
  output logic                 Error
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT, STEP, DONE, FAULT} state_t;
  state_t state;
`ifdef DELAY_WATCHDOG_EN
  logic [WatchdogBits-1:0] wd;
`endif
  // Outputs are registered alongside the state so each one reflects the state being entered.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      StartDelay <= 1'b0;
      Step       <= 1'b0;
      StepCount  <= '0;
      Done       <= 1'b0;
      Busy       <= 1'b0;
      Error      <= 1'b0;
`ifdef DELAY_WATCHDOG_EN
      wd         <= '0;
`endif
    end else begin
      Step       <= 1'b0;
      StartDelay <= 1'b0;
      case (state)
        IDLE: if (Run) begin
          state     <= ARM;
          Busy      <= 1'b1;
          StepCount <= '0;
        end
        ARM: if (!Run) begin
          state     <= IDLE;
          Busy      <= 1'b0;
          StepCount <= '0;
        end else begin
          state      <= WAIT;
          StartDelay <= 1'b1;
`ifdef DELAY_WATCHDOG_EN
          wd         <= '0;
`endif
        end
        // Abort outranks Timeout, and Timeout outranks the watchdog limit.
        WAIT: if (!Run) begin
          state     <= IDLE;
          Busy      <= 1'b0;
          StepCount <= '0;
        end else if (Timeout) begin
          state     <= STEP;
          Step      <= 1'b1;
          StepCount <= StepCount + 1'b1;
        end
`ifdef DELAY_WATCHDOG_EN
        else if (wd == WatchdogBits'(WatchdogLimit - 1)) begin
          state <= FAULT;
          Busy  <= 1'b0;
          Error <= 1'b1;
        end else begin
          wd         <= wd + 1'b1;
          StartDelay <= 1'b1;
        end
`else
        else StartDelay <= 1'b1;
`endif
        // Always passing back through WAIT means a held Timeout yields one Step per entry.
        STEP: if (!Run) begin
          state     <= IDLE;
          Busy      <= 1'b0;
          StepCount <= '0;
        end else if (StepCount == CountBits'(NumberOfSteps)) begin
          state <= DONE;
          Busy  <= 1'b0;
          Done  <= 1'b1;
        end else begin
          state      <= WAIT;
          StartDelay <= 1'b1;
`ifdef DELAY_WATCHDOG_EN
          wd         <= '0;
`endif
        end
        DONE, FAULT: if (!Run) begin
          state     <= IDLE;
          Done      <= 1'b0;
          Error     <= 1'b0;
          StepCount <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_step_controller.sv
// tb_delay_step_controller: directed bench for delay_step_controller with three steps per run.
module tb_delay_step_controller;
  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic       Run = 1'b0;
  logic       Timeout = 1'b0;
  logic       StartDelay, Step, Done, Busy, Error;
  logic [3:0] StepCount;
  int         checks = 0;
  int         errors = 0;

  delay_step_controller #(
    .NumberOfSteps(3),
    .CountBits(4),
    .WatchdogLimit(8),
    .WatchdogBits(4)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Run(Run),
    .Timeout(Timeout),
    .StartDelay(StartDelay),
    .Step(Step),
    .StepCount(StepCount),
    .Done(Done),
    .Busy(Busy),
    .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Compares all outputs at once: {StartDelay, Step, StepCount, Done, Busy, Error}.
  task automatic chk(input string tag, input int sd, input int st, input int cnt,
                     input int dn, input int bs, input int er);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {StartDelay, Step, StepCount, Done, Busy, Error};
    exp = {1'(sd), 1'(st), 4'(cnt), 1'(dn), 1'(bs), 1'(er)};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sd/st/cnt/dn/bs/er=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #2 Resetn = 1'b0;
    #1 chk("reset", 0, 0, 0, 0, 0, 0);
    #9 Resetn = 1'b1;
    tick();
    chk("idle", 0, 0, 0, 0, 0, 0);
    Run = 1'b1;
    tick();
    chk("arm", 0, 0, 0, 0, 1, 0);
    tick();
    chk("wait0", 1, 0, 0, 0, 1, 0);
    // Timer model: Timeout sampled on the fifth edge after StartDelay rises.
    for (int k = 1; k <= 3; k++) begin
      repeat (4) tick();
      chk("wait_pre", 1, 0, k - 1, 0, 1, 0);
      Timeout = 1'b1;
      tick();
      Timeout = 1'b0;
      chk("step", 0, 1, k, 0, 1, 0);
      if (k < 3) begin
        tick();
        chk("rewait", 1, 0, k, 0, 1, 0);
      end
    end
    tick();
    chk("done", 0, 0, 3, 1, 0, 0);
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk("done_hold", 0, 0, 3, 1, 0, 0);
    Run = 1'b0;
    tick();
    chk("done_to_idle", 0, 0, 0, 0, 0, 0);
    Run = 1'b1;
    tick();
    tick();
    chk("wait_abort_pre", 1, 0, 0, 0, 1, 0);
    Timeout = 1'b1;
    Run = 1'b0;
    tick();
    Timeout = 1'b0;
    chk("abort_beats_timeout", 0, 0, 0, 0, 0, 0);
    Run = 1'b1;
    tick();
    tick();
    Timeout = 1'b1;
    tick();
    chk("held_step1", 0, 1, 1, 0, 1, 0);
    tick();
    chk("held_wait1", 1, 0, 1, 0, 1, 0);
    tick();
    chk("held_step2", 0, 1, 2, 0, 1, 0);
    tick();
    chk("held_wait2", 1, 0, 2, 0, 1, 0);
    Timeout = 1'b0;
    tick();
    chk("held_after", 1, 0, 2, 0, 1, 0);
    #2 Resetn = 1'b0;
    #1 chk("async_reset", 0, 0, 0, 0, 0, 0);
    #3 Resetn = 1'b1;
    tick();
    chk("restart_arm", 0, 0, 0, 0, 1, 0);
    tick();
    chk("restart_wait", 1, 0, 0, 0, 1, 0);
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    Run = 1'b0;
    chk("step_pre_abort", 0, 1, 1, 0, 1, 0);
    tick();
    chk("abort_in_step", 0, 0, 0, 0, 0, 0);
    Run = 1'b1;
    tick();
    tick();
    repeat (7) tick();
    chk("wd_7", 1, 0, 0, 0, 1, 0);
    tick();
`ifdef DELAY_WATCHDOG_EN
    chk("wd_fault", 0, 0, 0, 0, 0, 1);
`else
    chk("wd_absent", 1, 0, 0, 0, 1, 0);
`endif
    Run = 1'b0;
    tick();
    chk("wd_to_idle", 0, 0, 0, 0, 0, 0);
    Run = 1'b1;
    tick();
    tick();
    repeat (7) tick();
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk("timeout_wins_limit", 0, 1, 1, 0, 1, 0);
    Run = 1'b0;
    tick();
    chk("final_idle", 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
